// File: rtl/match_scan_ctrl_pkg.sv
// Shared types and constants for the serial pattern-scan controller.
package match_scan_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int WIN_W = 3;

  // Bits needed to hold a count of 0..max_bits inclusive.
  function automatic int bit_cnt_width(input int max_bits);
    return $clog2(max_bits + 1);
  endfunction

endpackage

// File: rtl/Comparator3Bit.sv
// 3-bit equality comparator that sits between the window and the latched pattern.
module Comparator3Bit (
  input  logic [2:0] _A,
  input  logic [2:0] _B,
  output logic       out
);

  assign out = (_A == _B);

endmodule

// File: rtl/bit_window3.sv
// 3-bit serial shift window, newest bit in bit 0; clear has priority over shift.
module bit_window3
  import match_scan_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rstn,
  input  logic             clr,
  input  logic             shift_en,
  input  logic             din,
  output logic [WIN_W-1:0] win
);

  logic [WIN_W-1:0] win_reg;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      win_reg <= '0;
    end else if (clr) begin
      win_reg <= '0;
    end else if (shift_en) begin
      win_reg <= {win_reg[WIN_W-2:0], din};
    end
  end

  assign win = win_reg;

endmodule

// File: rtl/match_scan_ctrl.sv
// Frame controller: shifts MAX_BITS bits through the window and counts
// comparator matches (overlapping) into a saturating counter.
module match_scan_ctrl
  import match_scan_ctrl_pkg::*;
#(
  parameter int CNT_W    = 4,
  parameter int MAX_BITS = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic [WIN_W-1:0] pattern,
  input  logic             bit_in,
  input  logic             bit_valid,
  output logic             bit_ready,
  output logic [WIN_W-1:0] win,
  output logic [WIN_W-1:0] pat_out,
  input  logic             match,
  output logic [CNT_W-1:0] count,
  output logic             busy,
  output logic             done
);

  localparam int              BC_W      = bit_cnt_width(MAX_BITS);
  localparam logic [BC_W-1:0] LAST_BIT  = BC_W'(MAX_BITS);
  localparam logic [BC_W-1:0] FIRST_CHK = BC_W'(WIN_W);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  state_e            state_reg;
  logic [BC_W-1:0]   bit_cnt_reg;
  logic [BC_W-1:0]   bit_cnt_next;
  logic              chk_reg;
  logic [WIN_W-1:0]  pat_reg;
  logic [CNT_W-1:0]  count_reg;
  logic              bit_ready_reg;
  logic              busy_reg;
  logic              done_reg;
  logic              accept;
  logic              frame_start;

  // bit_ready_reg is high exactly while in SCAN, so accept never looks at state.
  assign accept       = bit_ready_reg && bit_valid;
  assign frame_start  = (state_reg == ST_IDLE) && start;
  assign bit_cnt_next = bit_cnt_reg + 1'b1;

  bit_window3 u_window (
    .clk      (clk),
    .rstn     (rstn),
    .clr      (frame_start),
    .shift_en (accept),
    .din      (bit_in),
    .win      (win)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg     <= ST_IDLE;
      bit_cnt_reg   <= '0;
      chk_reg       <= 1'b0;
      pat_reg       <= '0;
      count_reg     <= '0;
      bit_ready_reg <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      // chk marks a window that the comparator must be sampled for next cycle;
      // the first two bits of a frame leave a partially filled window.
      chk_reg <= accept && (bit_cnt_next >= FIRST_CHK);
      if (chk_reg && match && (count_reg != CNT_MAX)) begin
        count_reg <= count_reg + 1'b1;
      end

      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            pat_reg       <= pattern;
            count_reg     <= '0;
            bit_cnt_reg   <= '0;
            chk_reg       <= 1'b0;
            state_reg     <= ST_SCAN;
            bit_ready_reg <= 1'b1;
            busy_reg      <= 1'b1;
          end
        end
        ST_SCAN: begin
          if (accept) begin
            bit_cnt_reg <= bit_cnt_next;
            if (bit_cnt_next == LAST_BIT) begin
              state_reg     <= ST_FLUSH;
              bit_ready_reg <= 1'b0;
            end
          end
        end
        ST_FLUSH: begin
          state_reg <= ST_DONE;
          busy_reg  <= 1'b0;
          done_reg  <= 1'b1;
        end
        ST_DONE: begin
          state_reg <= ST_IDLE;
          done_reg  <= 1'b0;
        end
        default: begin
          state_reg     <= ST_IDLE;
          bit_ready_reg <= 1'b0;
          busy_reg      <= 1'b0;
          done_reg      <= 1'b0;
        end
      endcase
    end
  end

  assign bit_ready = bit_ready_reg;
  assign pat_out   = pat_reg;
  assign count     = count_reg;
  assign busy      = busy_reg;
  assign done      = done_reg;

endmodule

// File: tb/tb_match_scan_ctrl.sv
// Directed bench: five controller instances with different frame/counter sizes,
// each wired to its own Comparator3Bit.
module tb_match_scan_ctrl;

  localparam int NI = 5;

  logic       clk = 1'b0;
  logic       rstn;
  logic       start     [NI];
  logic [2:0] pattern   [NI];
  logic       bit_in    [NI];
  logic       bit_valid [NI];
  logic       bit_ready [NI];
  logic [2:0] win       [NI];
  logic [2:0] pat_out   [NI];
  logic       match     [NI];
  logic [3:0] count     [NI];
  logic       busy      [NI];
  logic       done      [NI];
  int         done_cnt  [NI];

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  // Instance map: 0:(4,16) 1:(4,5) 2:(4,4) 3:(4,3) 4:(2,10) as (CNT_W, MAX_BITS).
  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    localparam int CW = (gi == 4) ? 2 : 4;
    localparam int MB = (gi == 0) ? 16 : (gi == 1) ? 5 : (gi == 2) ? 4 : (gi == 3) ? 3 : 10;
    logic [CW-1:0] cnt_w;

    match_scan_ctrl #(.CNT_W(CW), .MAX_BITS(MB)) u_dut (
      .clk       (clk),
      .rstn      (rstn),
      .start     (start[gi]),
      .pattern   (pattern[gi]),
      .bit_in    (bit_in[gi]),
      .bit_valid (bit_valid[gi]),
      .bit_ready (bit_ready[gi]),
      .win       (win[gi]),
      .pat_out   (pat_out[gi]),
      .match     (match[gi]),
      .count     (cnt_w),
      .busy      (busy[gi]),
      .done      (done[gi])
    );

    Comparator3Bit u_cmp (
      ._A  (win[gi]),
      ._B  (pat_out[gi]),
      .out (match[gi])
    );

    assign count[gi] = 4'(cnt_w);
  end

  always @(posedge clk) begin
    for (int k = 0; k < NI; k++) begin
      if (done[k] === 1'b1) done_cnt[k] <= done_cnt[k] + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int i, input logic [2:0] p);
    start[i]   = 1'b1;
    pattern[i] = p;
    tick();
    start[i]   = 1'b0;
    $display("inst %0d start pattern=%b", i, p);
  endtask

  task automatic send_bit(input int i, input logic b);
    bit_valid[i] = 1'b1;
    bit_in[i]    = b;
    tick();
    bit_valid[i] = 1'b0;
    $display("inst %0d bit=%b win=%b count=%0d", i, b, win[i], count[i]);
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    tick();
    tick();
    for (int i = 0; i < NI; i++) begin
      total_cnt++;
      if (bit_ready[i] !== 1'b0 || busy[i] !== 1'b0 || done[i] !== 1'b0)
        $display("FAIL reset_ctrl inst %0d: ready/busy/done=%b%b%b expected 000", i, bit_ready[i], busy[i], done[i]);
      else pass_cnt++;
      total_cnt++;
      if (count[i] !== 4'd0 || pat_out[i] !== 3'b000 || win[i] !== 3'b000)
        $display("FAIL reset_data inst %0d: count=%0d pat=%b win=%b expected 0/000/000", i, count[i], pat_out[i], win[i]);
      else pass_cnt++;
    end
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_reset_mid_frame();
    logic [6:0] bits = 7'b0101001;
    int d0;
    do_start(0, 3'b010);
    for (int k = 6; k >= 0; k--) send_bit(0, bits[k]);
    total_cnt++;
    if (busy[0] !== 1'b1 || bit_ready[0] !== 1'b1 || pat_out[0] !== 3'b010)
      $display("FAIL midframe_pre: busy=%b ready=%b pat=%b expected 1 1 010", busy[0], bit_ready[0], pat_out[0]);
    else pass_cnt++;
    total_cnt++;
    if (count[0] !== 4'd2)
      $display("FAIL midframe_count: got %0d expected 2", count[0]);
    else pass_cnt++;
    d0 = done_cnt[0];
    rstn = 1'b0;
    #1;
    total_cnt++;
    if (bit_ready[0] !== 1'b0 || busy[0] !== 1'b0 || count[0] !== 4'd0 || pat_out[0] !== 3'b000 || win[0] !== 3'b000)
      $display("FAIL midframe_async_reset: ready=%b busy=%b count=%0d pat=%b win=%b expected 0 0 0 000 000",
               bit_ready[0], busy[0], count[0], pat_out[0], win[0]);
    else pass_cnt++;
    tick();
    tick();
    rstn = 1'b1;
    for (int k = 0; k < 20; k++) tick();
    total_cnt++;
    if (done_cnt[0] !== d0 || busy[0] !== 1'b0)
      $display("FAIL midframe_no_done: done pulses=%0d busy=%b expected %0d 0", done_cnt[0], busy[0], d0);
    else pass_cnt++;
    $display("frame inst 0 aborted by reset");
  endtask

  task automatic test_overlap();
    logic [4:0] bits = 5'b10101;
    int d0 = done_cnt[1];
    do_start(1, 3'b101);
    total_cnt++;
    if (bit_ready[1] !== 1'b1 || busy[1] !== 1'b1 || count[1] !== 4'd0)
      $display("FAIL overlap_scan_entry: ready=%b busy=%b count=%0d expected 1 1 0", bit_ready[1], busy[1], count[1]);
    else pass_cnt++;
    for (int k = 4; k >= 0; k--) send_bit(1, bits[k]);
    total_cnt++;
    if (bit_ready[1] !== 1'b0 || busy[1] !== 1'b1 || done[1] !== 1'b0)
      $display("FAIL overlap_flush: ready=%b busy=%b done=%b expected 0 1 0", bit_ready[1], busy[1], done[1]);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (done[1] !== 1'b1 || count[1] !== 4'd2 || busy[1] !== 1'b0)
      $display("FAIL overlap_done: done=%b count=%0d busy=%b expected 1 2 0", done[1], count[1], busy[1]);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (done[1] !== 1'b0 || count[1] !== 4'd2 || done_cnt[1] !== d0 + 1)
      $display("FAIL overlap_idle: done=%b count=%0d pulses=%0d expected 0 2 %0d", done[1], count[1], done_cnt[1] - d0, 1);
    else pass_cnt++;
    $display("frame inst 1 count=%0d", count[1]);
  endtask

  task automatic test_startup_exclusion();
    do_start(2, 3'b000);
    send_bit(2, 1'b0);
    send_bit(2, 1'b0);
    tick();
    tick();
    total_cnt++;
    if (count[2] !== 4'd0 || win[2] !== 3'b000)
      $display("FAIL startup_no_early_check: count=%0d win=%b expected 0 000", count[2], win[2]);
    else pass_cnt++;
    send_bit(2, 1'b0);
    send_bit(2, 1'b0);
    tick();
    total_cnt++;
    if (done[2] !== 1'b1 || count[2] !== 4'd2)
      $display("FAIL startup_count: done=%b count=%0d expected 1 2", done[2], count[2]);
    else pass_cnt++;
    tick();
    $display("frame inst 2 count=%0d", count[2]);
  endtask

  task automatic test_bubbles();
    do_start(3, 3'b111);
    send_bit(3, 1'b1);
    tick();
    start[3] = 1'b1;
    pattern[3] = 3'b000;
    tick();
    start[3] = 1'b0;
    total_cnt++;
    if (pat_out[3] !== 3'b111 || busy[3] !== 1'b1 || bit_ready[3] !== 1'b1 || win[3] !== 3'b001)
      $display("FAIL bubble_ignored_start: pat=%b busy=%b ready=%b win=%b expected 111 1 1 001",
               pat_out[3], busy[3], bit_ready[3], win[3]);
    else pass_cnt++;
    send_bit(3, 1'b1);
    tick();
    tick();
    total_cnt++;
    if (win[3] !== 3'b011 || count[3] !== 4'd0 || bit_ready[3] !== 1'b1)
      $display("FAIL bubble_stall: win=%b count=%0d ready=%b expected 011 0 1", win[3], count[3], bit_ready[3]);
    else pass_cnt++;
    send_bit(3, 1'b1);
    tick();
    total_cnt++;
    if (done[3] !== 1'b1 || count[3] !== 4'd1 || pat_out[3] !== 3'b111)
      $display("FAIL bubble_result: done=%b count=%0d pat=%b expected 1 1 111", done[3], count[3], pat_out[3]);
    else pass_cnt++;
    tick();
    $display("frame inst 3 count=%0d", count[3]);
  endtask

  task automatic test_saturation();
    do_start(4, 3'b111);
    for (int k = 0; k < 8; k++) send_bit(4, 1'b1);
    total_cnt++;
    if (count[4] !== 4'd3)
      $display("FAIL sat_mid: count=%0d expected 3", count[4]);
    else pass_cnt++;
    send_bit(4, 1'b1);
    send_bit(4, 1'b1);
    tick();
    total_cnt++;
    if (done[4] !== 1'b1 || count[4] !== 4'd3)
      $display("FAIL sat_final: done=%b count=%0d expected 1 3", done[4], count[4]);
    else pass_cnt++;
    tick();
    $display("frame inst 4 count=%0d", count[4]);
  endtask

  task automatic test_back_to_back();
    logic [4:0] bits2 = 5'b11011;
    int d0;
    do_start(1, 3'b111);
    for (int k = 0; k < 5; k++) send_bit(1, 1'b1);
    tick();
    total_cnt++;
    if (done[1] !== 1'b1 || count[1] !== 4'd3)
      $display("FAIL b2b_first: done=%b count=%0d expected 1 3", done[1], count[1]);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (count[1] !== 4'd3 || pat_out[1] !== 3'b111 || busy[1] !== 1'b0)
      $display("FAIL b2b_idle_hold: count=%0d pat=%b busy=%b expected 3 111 0", count[1], pat_out[1], busy[1]);
    else pass_cnt++;
    d0 = done_cnt[1];
    do_start(1, 3'b011);
    total_cnt++;
    if (count[1] !== 4'd0 || pat_out[1] !== 3'b011 || busy[1] !== 1'b1)
      $display("FAIL b2b_restart: count=%0d pat=%b busy=%b expected 0 011 1", count[1], pat_out[1], busy[1]);
    else pass_cnt++;
    for (int k = 4; k >= 0; k--) send_bit(1, bits2[k]);
    tick();
    total_cnt++;
    if (done[1] !== 1'b1 || count[1] !== 4'd1)
      $display("FAIL b2b_second: done=%b count=%0d expected 1 1", done[1], count[1]);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (done_cnt[1] !== d0 + 1)
      $display("FAIL b2b_pulses: got %0d expected 1", done_cnt[1] - d0);
    else pass_cnt++;
    $display("frame inst 1 second count=%0d", count[1]);
  endtask

  initial begin
    for (int i = 0; i < NI; i++) begin
      start[i]     = 1'b0;
      pattern[i]   = 3'b000;
      bit_in[i]    = 1'b0;
      bit_valid[i] = 1'b0;
      done_cnt[i]  = 0;
    end
    test_reset();
    test_reset_mid_frame();
    test_overlap();
    test_startup_exclusion();
    test_bubbles();
    test_saturation();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
